// File: rtl/fpsu_wb_sched.sv
// fpsu_wb_sched: grants FP add/sub issue only into free writeback slots; long ops share one round-robin stage
module fpsu_wb_sched #(
    parameter int LAT_SHORT = 3,
    parameter int LAT_LONG  = 5,
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [2:0]         req,
    input  logic [2:0]         req_long,
    input  logic [3*TAG_W-1:0] req_tag,
    output logic [2:0]         gnt,
    output logic [2:0]         wb_en,
    output logic [3*TAG_W-1:0] wb_tag,
    output logic [2:0]         busy
);
    localparam logic [DEPTH-1:0] S_BIT = DEPTH'(1) << (LAT_SHORT - 1);
    localparam logic [DEPTH-1:0] L_BIT = DEPTH'(1) << (LAT_LONG - 1);
    logic [2:0][DEPTH-1:0]            res_q, res_d;
    logic [2:0][DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [1:0]                       rr_q, rr_d, win;
    logic [2:0]                       s_gnt, l_elig, l_gnt, idx;
    logic                             found;

    always_comb begin
        s_gnt  = '0;
        l_elig = '0;
        l_gnt  = '0;
        found  = 1'b0;
        win    = rr_q;
        idx    = '0;
        for (int i = 0; i < 3; i++) begin
            s_gnt[i]  = req[i] & ~req_long[i] & ~res_q[i][LAT_SHORT] & ~flush;
            l_elig[i] = req[i] & req_long[i] & ~res_q[i][LAT_LONG] & ~flush;
        end
        // first eligible long request at or after rr_q wins the shared stage
        for (int i = 0; i < 3; i++) begin
            idx = {1'b0, rr_q} + 3'(i);
            idx = idx >= 3'd3 ? idx - 3'd3 : idx;
            if (!found && l_elig[idx[1:0]]) begin
                found           = 1'b1;
                l_gnt[idx[1:0]] = 1'b1;
                win             = idx[1:0];
            end
        end
        gnt  = s_gnt | l_gnt;
        rr_d = found ? (win == 2'd2 ? 2'd0 : win + 2'd1) : rr_q;
    end

    always_comb begin
        res_d  = '0;
        tag_d  = '0;
        wb_en  = '0;
        wb_tag = '0;
        busy   = '0;
        for (int p = 0; p < 3; p++) begin
            res_d[p] = (res_q[p] >> 1) | (gnt[p] ? (req_long[p] ? L_BIT : S_BIT) : '0);
            tag_d[p] = tag_q[p] >> TAG_W;
            if (gnt[p] && req_long[p]) tag_d[p][LAT_LONG-1] = req_tag[p*TAG_W +: TAG_W];
            if (gnt[p] && !req_long[p]) tag_d[p][LAT_SHORT-1] = req_tag[p*TAG_W +: TAG_W];
            res_d[p] = flush ? '0 : res_d[p];
            tag_d[p] = flush ? '0 : tag_d[p];
            wb_en[p] = res_q[p][0];
            busy[p]  = |res_q[p];
            wb_tag[p*TAG_W +: TAG_W] = tag_q[p][0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            tag_q <= '0;
            rr_q  <= '0;
        end else begin
            res_q <= res_d;
            tag_q <= tag_d;
            rr_q  <= rr_d;
        end
    end
endmodule

// File: tb/tb_fpsu_wb_sched.sv
// tb_fpsu_wb_sched: directed checks of grant gating, writeback timing, round-robin, flush and reset
module tb_fpsu_wb_sched;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [2:0]  req, req_long, gnt, wb_en, busy;
    logic [26:0] req_tag, wb_tag;
    int          n_cmp = 0;
    int          n_bad = 0;

    fpsu_wb_sched dut (
        .clk(clk), .rst(rst), .flush(flush), .req(req), .req_long(req_long),
        .req_tag(req_tag), .gnt(gnt), .wb_en(wb_en), .wb_tag(wb_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] l,
                         input logic [8:0] t0, input logic [8:0] t1, input logic [8:0] t2);
        req      = r;
        req_long = l;
        req_tag  = {t2, t1, t0};
    endtask

    task automatic chk3(input string name, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", name, obs, exp);
        end
    endtask

    task automatic chk27(input string name, input logic [26:0] obs, input logic [26:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(3'b000, 3'b000, 9'h0, 9'h0, 9'h0);
        nxt(); nxt();
        rst = 1'b0;
        #1;
        chk3("rst_wb_en", wb_en, 3'b000);
        chk3("rst_busy", busy, 3'b000);
        chk27("rst_wb_tag", wb_tag, 27'h0);
        // short op on port 0: writeback three cycles after grant
        nxt(); drive(3'b001, 3'b000, 9'h011, 9'h0, 9'h0); #1;
        chk3("t1_gnt", gnt, 3'b001);
        nxt(); drive(3'b000, 3'b000, 9'h0, 9'h0, 9'h0); #1;
        chk3("t1_wb_t1", wb_en, 3'b000);
        chk3("t1_busy_t1", busy, 3'b001);
        nxt(); #1;
        chk3("t1_wb_t2", wb_en, 3'b000);
        nxt(); #1;
        chk3("t1_wb_t3", wb_en, 3'b001);
        chk27("t1_tag_t3", wb_tag, {9'h0, 9'h0, 9'h011});
        nxt(); #1;
        chk3("t1_wb_t4", wb_en, 3'b000);
        chk3("t1_busy_t4", busy, 3'b000);
        // long then colliding short on port 1
        nxt(); drive(3'b010, 3'b010, 9'h0, 9'h0A1, 9'h0); #1;
        chk3("t2_gnt_long", gnt, 3'b010);
        nxt(); drive(3'b000, 3'b000, 9'h0, 9'h0, 9'h0); #1;
        nxt(); drive(3'b010, 3'b000, 9'h0, 9'h0B2, 9'h0); #1;
        chk3("t2_gnt_withheld", gnt, 3'b000);
        nxt(); #1;
        chk3("t2_gnt_short", gnt, 3'b010);
        nxt(); drive(3'b000, 3'b000, 9'h0, 9'h0, 9'h0); #1;
        chk3("t2_wb_t4", wb_en, 3'b000);
        nxt(); #1;
        chk3("t2_wb_t5", wb_en, 3'b010);
        chk27("t2_tag_t5", wb_tag, {9'h0, 9'h0A1, 9'h0});
        nxt(); #1;
        chk3("t2_wb_t6", wb_en, 3'b010);
        chk27("t2_tag_t6", wb_tag, {9'h0, 9'h0B2, 9'h0});
        nxt(); #1;
        chk3("t2_wb_t7", wb_en, 3'b000);
        // reset to bring rr_ptr back to 0, then round-robin long ops
        nxt(); rst = 1'b1; #1;
        nxt(); rst = 1'b0; #1;
        nxt(); drive(3'b111, 3'b111, 9'h100, 9'h101, 9'h102); #1;
        chk3("t3_gnt_a", gnt, 3'b001);
        nxt(); #1;
        chk3("t3_gnt_b", gnt, 3'b010);
        nxt(); #1;
        chk3("t3_gnt_c", gnt, 3'b100);
        nxt(); #1;
        chk3("t3_gnt_d", gnt, 3'b001);
        nxt(); drive(3'b000, 3'b000, 9'h0, 9'h0, 9'h0); #1;
        chk3("t3_wb_a4", wb_en, 3'b000);
        nxt(); #1;
        chk3("t3_wb_a5", wb_en, 3'b001);
        nxt(); #1;
        chk3("t3_wb_a6", wb_en, 3'b010);
        chk27("t3_tag_a6", wb_tag, {9'h0, 9'h101, 9'h0});
        nxt(); #1;
        chk3("t3_wb_a7", wb_en, 3'b100);
        nxt(); #1;
        chk3("t3_wb_a8", wb_en, 3'b001);
        nxt(); #1;
        chk3("t3_busy_a9", busy, 3'b000);
        // long on port 2 together with short on port 0
        nxt(); drive(3'b101, 3'b100, 9'h041, 9'h0, 9'h142); #1;
        chk3("t4_gnt", gnt, 3'b101);
        nxt(); drive(3'b000, 3'b000, 9'h0, 9'h0, 9'h0); #1;
        nxt(); #1;
        nxt(); #1;
        chk3("t4_wb_t3", wb_en, 3'b001);
        chk27("t4_tag_t3", wb_tag, {9'h0, 9'h0, 9'h041});
        nxt(); #1;
        chk3("t4_wb_t4", wb_en, 3'b000);
        nxt(); #1;
        chk3("t4_wb_t5", wb_en, 3'b100);
        chk27("t4_tag_t5", wb_tag, {9'h142, 9'h0, 9'h0});
        // flush with three ops in flight
        nxt(); drive(3'b001, 3'b000, 9'h051, 9'h0, 9'h0); #1;
        chk3("t5_gnt_t0", gnt, 3'b001);
        nxt(); drive(3'b010, 3'b000, 9'h0, 9'h052, 9'h0); #1;
        chk3("t5_gnt_t1", gnt, 3'b010);
        nxt(); drive(3'b010, 3'b010, 9'h0, 9'h053, 9'h0); #1;
        chk3("t5_gnt_t2", gnt, 3'b010);
        nxt(); drive(3'b001, 3'b000, 9'h054, 9'h0, 9'h0); flush = 1'b1; #1;
        chk3("t5_gnt_flush", gnt, 3'b000);
        chk3("t5_wb_flush", wb_en, 3'b001);
        chk3("t5_busy_flush", busy, 3'b011);
        nxt(); flush = 1'b0; drive(3'b000, 3'b000, 9'h0, 9'h0, 9'h0); #1;
        chk3("t5_wb_t4", wb_en, 3'b000);
        chk3("t5_busy_t4", busy, 3'b000);
        nxt(); #1;
        chk3("t5_wb_t5", wb_en, 3'b000);
        nxt(); drive(3'b111, 3'b111, 9'h061, 9'h062, 9'h063); #1;
        chk3("t5_rr_held", gnt, 3'b100);
        // reset with four ops in flight
        nxt(); drive(3'b011, 3'b010, 9'h071, 9'h072, 9'h0); #1;
        chk3("t6_gnt_x1", gnt, 3'b011);
        nxt(); drive(3'b001, 3'b000, 9'h073, 9'h0, 9'h0); #1;
        chk3("t6_gnt_x2", gnt, 3'b001);
        nxt(); drive(3'b000, 3'b000, 9'h0, 9'h0, 9'h0); rst = 1'b1; #1;
        chk3("t6_busy_pre", busy, 3'b111);
        nxt(); rst = 1'b0; #1;
        chk3("t6_wb_post", wb_en, 3'b000);
        chk3("t6_busy_post", busy, 3'b000);
        chk27("t6_tag_post", wb_tag, 27'h0);
        drive(3'b111, 3'b111, 9'h081, 9'h082, 9'h083); #1;
        chk3("t6_rr_zero", gnt, 3'b001);
        nxt(); drive(3'b000, 3'b000, 9'h0, 9'h0, 9'h0); #1;
        chk3("t6_wb_next", wb_en, 3'b000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
